// File: rtl/sif_pkg.sv
// Shared types and helpers for the complex serial-interface (sif) datapath blocks.
package sif_pkg;

  localparam int SIF_WIDTH = 16;

  typedef struct packed {
    logic [SIF_WIDTH-1:0] re;
    logic [SIF_WIDTH-1:0] img;
  } cplx_t;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_PAIR = 1'b1
  } sif_state_e;

  // Index width for a butterfly span; a span of 1 still needs a 1-bit index port.
  function automatic int sif_idx_w(input int stride);
    return (stride <= 1) ? 1 : $clog2(stride);
  endfunction

endpackage

// File: rtl/sif_cplx_ram.sv
// STRIDE-deep complex sample store: one synchronous write port, one asynchronous read port.
module sif_cplx_ram #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wr_real,
  input  logic [WIDTH-1:0] wr_img,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rd_real,
  output logic [WIDTH-1:0] rd_img
);

  // Contents need no reset: every entry is written in FILL before PAIR reads it.
  logic [2*WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= {wr_real, wr_img};
    end
  end

  assign {rd_real, rd_img} = mem_q[raddr];

endmodule

// File: rtl/sif_pair_split_complex.sv
// Regroups a serial complex stream into butterfly operand pairs (x[k], x[k+STRIDE]) with pair index k.
module sif_pair_split_complex
  import sif_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int STRIDE = 4,
  parameter int IDX_W  = sif_idx_w(STRIDE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             I_vld,
  input  logic [WIDTH-1:0] I_real_dat,
  input  logic [WIDTH-1:0] I_img_dat,
  output logic             I_rdy,
  output logic             A_vld,
  output logic [WIDTH-1:0] A_real_dat,
  output logic [WIDTH-1:0] A_img_dat,
  input  logic             A_rdy,
  output logic             B_vld,
  output logic [WIDTH-1:0] B_real_dat,
  output logic [WIDTH-1:0] B_img_dat,
  input  logic             B_rdy,
  output logic [IDX_W-1:0] P_idx
);

  sif_state_e       state_q, state_d;
  logic [IDX_W-1:0] cnt_q, cnt_d;
  logic             vld_q, vld_d;
  logic [WIDTH-1:0] a_real_q, a_real_d;
  logic [WIDTH-1:0] a_img_q, a_img_d;
  logic [WIDTH-1:0] b_real_q, b_real_d;
  logic [WIDTH-1:0] b_img_q, b_img_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic             pop;
  logic             i_rdy;
  logic             accept;
  logic             last;
  logic             ram_we;
  logic             load;
  logic [WIDTH-1:0] rd_real;
  logic [WIDTH-1:0] rd_img;

  sif_cplx_ram #(
    .WIDTH (WIDTH),
    .DEPTH (STRIDE),
    .AW    (IDX_W)
  ) u_ram (
    .clk     (clk),
    .we      (ram_we),
    .waddr   (cnt_q),
    .wr_real (I_real_dat),
    .wr_img  (I_img_dat),
    .raddr   (cnt_q),
    .rd_real (rd_real),
    .rd_img  (rd_img)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    vld_d    = vld_q;
    a_real_d = a_real_q;
    a_img_d  = a_img_q;
    b_real_d = b_real_q;
    b_img_d  = b_img_q;
    idx_d    = idx_q;

    // A pair is consumed only when both operand consumers take it together.
    pop    = vld_q & A_rdy & B_rdy;
    i_rdy  = (state_q == ST_FILL) ? 1'b1 : (!vld_q | pop);
    accept = I_vld & i_rdy;
    last   = (cnt_q == IDX_W'(STRIDE - 1));
    ram_we = accept & (state_q == ST_FILL);
    load   = accept & (state_q == ST_PAIR);

    if (accept) begin
      if (last) begin
        cnt_d   = '0;
        state_d = (state_q == ST_FILL) ? ST_PAIR : ST_FILL;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end

    // Load wins over pop so a simultaneous pop+load streams without a bubble.
    if (load) begin
      vld_d    = 1'b1;
      a_real_d = rd_real;
      a_img_d  = rd_img;
      b_real_d = I_real_dat;
      b_img_d  = I_img_dat;
      idx_d    = cnt_q;
    end else if (pop) begin
      vld_d = 1'b0;
    end
  end

  // ---- output register stage ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_FILL;
      cnt_q    <= '0;
      vld_q    <= 1'b0;
      a_real_q <= '0;
      a_img_q  <= '0;
      b_real_q <= '0;
      b_img_q  <= '0;
      idx_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      vld_q    <= vld_d;
      a_real_q <= a_real_d;
      a_img_q  <= a_img_d;
      b_real_q <= b_real_d;
      b_img_q  <= b_img_d;
      idx_q    <= idx_d;
    end
  end

  assign I_rdy      = i_rdy;
  assign A_vld      = vld_q;
  assign B_vld      = vld_q;
  assign A_real_dat = a_real_q;
  assign A_img_dat  = a_img_q;
  assign B_real_dat = b_real_q;
  assign B_img_dat  = b_img_q;
  assign P_idx      = idx_q;

endmodule

// File: tb/tb_sif_pair_split_complex.sv
// Directed bench for sif_pair_split_complex at STRIDE=4 and STRIDE=1.
module tb_sif_pair_split_complex;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        i_vld, i_rdy, a_vld, a_rdy, b_vld, b_rdy;
  logic [15:0] i_real, i_img, a_real, a_img, b_real, b_img;
  logic [1:0]  p_idx;

  logic        j_vld, j_rdy, j_avld, j_ardy, j_bvld, j_brdy;
  logic [15:0] j_real, j_img, j_areal, j_aimg, j_breal, j_bimg;
  logic [0:0]  j_idx;

  sif_pair_split_complex #(.WIDTH(16), .STRIDE(4), .IDX_W(2)) dut0 (
    .clk(clk), .rst(rst),
    .I_vld(i_vld), .I_real_dat(i_real), .I_img_dat(i_img), .I_rdy(i_rdy),
    .A_vld(a_vld), .A_real_dat(a_real), .A_img_dat(a_img), .A_rdy(a_rdy),
    .B_vld(b_vld), .B_real_dat(b_real), .B_img_dat(b_img), .B_rdy(b_rdy),
    .P_idx(p_idx)
  );

  sif_pair_split_complex #(.WIDTH(16), .STRIDE(1), .IDX_W(1)) dut1 (
    .clk(clk), .rst(rst),
    .I_vld(j_vld), .I_real_dat(j_real), .I_img_dat(j_img), .I_rdy(j_rdy),
    .A_vld(j_avld), .A_real_dat(j_areal), .A_img_dat(j_aimg), .A_rdy(j_ardy),
    .B_vld(j_bvld), .B_real_dat(j_breal), .B_img_dat(j_bimg), .B_rdy(j_brdy),
    .P_idx(j_idx)
  );

  int total = 0;
  int bad   = 0;
  logic [65:0] expq[$];

  logic        c_irdy, c_avld, c_acc;
  logic [15:0] c_ar, c_br;
  logic [1:0]  c_idx;

  function automatic logic [15:0] xr(input int n);
    return 16'h1000 + n[15:0];
  endfunction

  function automatic logic [15:0] xi(input int n);
    return 16'h2000 + n[15:0];
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_pair(input int a, input int b, input int idx);
    logic [1:0] k;
    k = idx[1:0];
    expq.push_back({xr(a), xi(a), xr(b), xi(b), k});
  endtask

  // One clock: drive at negedge, sample just after, check any pop against the expected queue.
  task automatic cycle(input logic v, input int n, input logic ar, input logic br);
    logic [65:0] e;
    i_vld  = v;
    i_real = xr(n);
    i_img  = xi(n);
    a_rdy  = ar;
    b_rdy  = br;
    #1;
    c_irdy = i_rdy;
    c_avld = a_vld;
    c_ar   = a_real;
    c_br   = b_real;
    c_idx  = p_idx;
    c_acc  = v & i_rdy;
    chk("b_vld_tracks_a_vld", 64'(b_vld), 64'(a_vld));
    if (a_vld && ar && br) begin
      total++;
      assert (expq.size() != 0) else begin
        bad++;
        $error("FAIL pop_unexpected observed=pop a=%0h b=%0h expected=no_pop", a_real, b_real);
      end
      if (expq.size() != 0) begin
        e = expq.pop_front();
        chk("pair_a", {32'h0, a_real, a_img}, {32'h0, e[65:34]});
        chk("pair_b", {32'h0, b_real, b_img}, {32'h0, e[33:2]});
        chk("pair_idx", 64'(p_idx), 64'(e[1:0]));
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic send(input int n, input logic ar, input logic br);
    int k;
    k = 0;
    do begin
      cycle(1'b1, n, ar, br);
      k++;
    end while (!c_acc && k < 40);
    chk("send_accept", 64'(c_acc), 64'd1);
  endtask

  task automatic drain(input int cycles);
    for (int k = 0; k < cycles; k++) cycle(1'b0, 0, 1'b1, 1'b1);
    chk("drained", 64'(expq.size()), 64'd0);
  endtask

  task automatic j_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    i_vld = 1'b0; i_real = '0; i_img = '0; a_rdy = 1'b0; b_rdy = 1'b0;
    j_vld = 1'b0; j_real = '0; j_img = '0; j_ardy = 1'b1; j_brdy = 1'b1;
    repeat (2) @(negedge clk);

    // Reset state
    chk("rst_a_vld", 64'(a_vld), 64'd0);
    chk("rst_b_vld", 64'(b_vld), 64'd0);
    chk("rst_a_data", {32'h0, a_real, a_img}, 64'd0);
    chk("rst_b_data", {32'h0, b_real, b_img}, 64'd0);
    chk("rst_p_idx", 64'(p_idx), 64'd0);
    chk("rst_i_rdy", 64'(i_rdy), 64'd1);
    rst = 1'b0;
    @(negedge clk);

    // Basic group, readies high: I_rdy never drops
    for (int k = 0; k < 4; k++) push_pair(k, k + 4, k);
    for (int n = 0; n < 8; n++) begin
      cycle(1'b1, n, 1'b1, 1'b1);
      chk("t1_i_rdy", 64'(c_irdy), 64'd1);
    end
    drain(3);

    // Consumer stall after the first pair
    for (int k = 0; k < 4; k++) push_pair(k, k + 4, k);
    for (int n = 0; n < 5; n++) send(n, 1'b1, 1'b1);
    for (int s = 0; s < 5; s++) begin
      cycle(1'b1, 5, 1'b0, 1'b0);
      chk("t2_i_rdy_low", 64'(c_irdy), 64'd0);
      chk("t2_a_vld", 64'(c_avld), 64'd1);
      chk("t2_hold_a", 64'(c_ar), 64'(xr(0)));
      chk("t2_hold_b", 64'(c_br), 64'(xr(4)));
      chk("t2_hold_idx", 64'(c_idx), 64'd0);
    end
    for (int n = 5; n < 8; n++) send(n, 1'b1, 1'b1);
    drain(3);

    // Lone A_rdy consumes nothing
    for (int k = 0; k < 4; k++) push_pair(k, k + 4, k);
    for (int n = 0; n < 5; n++) send(n, 1'b1, 1'b1);
    for (int s = 0; s < 3; s++) begin
      cycle(1'b0, 0, 1'b1, 1'b0);
      chk("t3_a_vld_held", 64'(c_avld), 64'd1);
      chk("t3_a_held", 64'(c_ar), 64'(xr(0)));
    end
    cycle(1'b0, 0, 1'b1, 1'b1);
    cycle(1'b0, 0, 1'b1, 1'b1);
    chk("t3_popped_once", 64'(c_avld), 64'd0);
    chk("t3_queue_advanced", 64'(expq.size()), 64'd3);
    for (int n = 5; n < 8; n++) send(n, 1'b1, 1'b1);
    drain(3);

    // STRIDE=1: (1+1j, 2+2j) then (3+3j, 4+4j)
    j_vld = 1'b1; j_real = 16'd1; j_img = 16'd1;
    j_step();
    j_real = 16'd2; j_img = 16'd2;
    j_step();
    chk("s1_p0_vld", 64'(j_avld), 64'd1);
    chk("s1_p0_a", {32'h0, j_areal, j_aimg}, 64'h0001_0001);
    chk("s1_p0_b", {32'h0, j_breal, j_bimg}, 64'h0002_0002);
    chk("s1_p0_idx", 64'(j_idx), 64'd0);
    j_real = 16'd3; j_img = 16'd3;
    j_step();
    chk("s1_gap_vld", 64'(j_avld), 64'd0);
    j_real = 16'd4; j_img = 16'd4;
    j_step();
    chk("s1_p1_vld", 64'(j_avld), 64'd1);
    chk("s1_p1_a", {32'h0, j_areal, j_aimg}, 64'h0003_0003);
    chk("s1_p1_b", {32'h0, j_breal, j_bimg}, 64'h0004_0004);
    chk("s1_p1_idx", 64'(j_idx), 64'd0);
    j_vld = 1'b0;
    j_step();
    chk("s1_end_vld", 64'(j_avld), 64'd0);

    // Two back-to-back groups
    for (int g = 0; g < 2; g++)
      for (int k = 0; k < 4; k++) push_pair(8 * g + k, 8 * g + k + 4, k);
    for (int n = 0; n < 16; n++) begin
      cycle(1'b1, n, 1'b1, 1'b1);
      chk("t5_accept", 64'(c_acc), 64'd1);
    end
    drain(3);

    // Reset mid-group: (x1,x5) pending and x6,x7 never arrive
    push_pair(0, 4, 0);
    for (int n = 0; n < 6; n++) send(n, 1'b1, 1'b1);
    rst = 1'b1;
    #1;
    chk("t6_a_vld", 64'(a_vld), 64'd0);
    chk("t6_a_data", {32'h0, a_real, a_img}, 64'd0);
    chk("t6_b_data", {32'h0, b_real, b_img}, 64'd0);
    chk("t6_p_idx", 64'(p_idx), 64'd0);
    chk("t6_i_rdy", 64'(i_rdy), 64'd1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 4; k++) push_pair(200 + k, 204 + k, k);
    for (int n = 200; n < 208; n++) send(n, 1'b1, 1'b1);
    drain(3);

    // Random I_vld and equal readies against a reference pairing model
    begin
      int n, cyc, j;
      logic v, r;
      n = 0;
      cyc = 0;
      while (n < 400 && cyc < 4000) begin
        v = 1'($urandom_range(0, 1));
        r = 1'($urandom_range(0, 1));
        cycle(v, 300 + n, r, r);
        if (c_acc) begin
          j = n % 8;
          if (j >= 4) push_pair(300 + n - 4, 300 + n, j - 4);
          n++;
        end
        cyc++;
      end
      chk("t7_samples", 64'(n), 64'd400);
      drain(4);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
